// File: rtl/mem_bridge.sv
// CPU-to-RAM bridge: posted write buffer drained in order, reads serialized behind it, timeout abort.
// Optional build macro WB_FWD_EN: reads that hit a buffered entry are answered from the buffer.
module mem_bridge #(
  parameter int WB_DEPTH   = 4,
  parameter int RD_TIMEOUT = 255
) (
  input  logic        clock_i,
  input  logic        reset_i,      // active-low, asynchronous
  input  logic        cpu_req_i,
  input  logic        cpu_wr_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_ack_o,
  output logic        cpu_stall_o,
  output logic        mem_req_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i,
  output logic        bus_err_o
);
  localparam int AW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(WB_DEPTH);
  localparam logic [15:0]   TMO_LAST = 16'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, RD_WAIT} state_t;

  logic [31:0]   wb_addr_q [WB_DEPTH];
  logic [31:0]   wb_data_q [WB_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_inc;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q;
  logic [15:0]   tmo_q;
  logic          mem_req_q, mem_wr_q, cpu_ack_q, bus_err_q;
  logic [31:0]   mem_addr_q, mem_wdata_q, cpu_rdata_q;

  logic wr_acc, rd_plain, rd_fwd, rd_acc, done, timed_out, pop;
  logic [31:0] fwd_data;

  assign wr_acc   = cpu_req_i & cpu_wr_i & (count_q < DEPTH_C) & (state_q != RD_WAIT);
  assign rd_plain = cpu_req_i & ~cpu_wr_i & (state_q == IDLE) & (count_q == '0);

`ifdef WB_FWD_EN
  logic fwd_hit;
  // Scan oldest to youngest so the last match (youngest entry) wins.
  always_comb begin
    logic [AW-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      idx = rd_ptr_q + AW'(i);
      if ((CW'(i) < count_q) && (wb_addr_q[idx] == cpu_addr_i)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data_q[idx];
      end
    end
  end
  assign rd_fwd = cpu_req_i & ~cpu_wr_i & (state_q != RD_WAIT) & fwd_hit;
`else
  assign rd_fwd   = 1'b0;
  assign fwd_data = '0;
`endif

  assign rd_acc      = rd_plain | rd_fwd;
  assign cpu_stall_o = cpu_req_i & ~(wr_acc | rd_acc);

  assign done       = mem_req_q & mem_ready_i;
  assign timed_out  = mem_req_q & ~mem_ready_i & (tmo_q == TMO_LAST);
  assign pop        = (state_q == DRAIN) & (done | timed_out);
  assign count_d    = count_q + CW'(wr_acc) - CW'(pop);
  assign rd_ptr_inc = rd_ptr_q + 1'b1;

  // Buffer storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clock_i) begin
    if (wr_acc) begin
      wb_addr_q[wr_ptr_q] <= cpu_addr_i;
      wb_data_q[wr_ptr_q] <= cpu_wdata_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      cpu_ack_q <= wr_acc;
      count_q   <= count_d;
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_inc;
      if (rd_fwd) begin
        cpu_rdata_q <= fwd_data;
        cpu_ack_q   <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            mem_addr_q  <= wb_addr_q[rd_ptr_q];
            mem_wdata_q <= wb_data_q[rd_ptr_q];
            mem_wr_q    <= 1'b1;
            mem_req_q   <= 1'b1;
            tmo_q       <= '0;
            state_q     <= DRAIN;
          end else if (rd_plain) begin
            mem_addr_q <= cpu_addr_i;
            mem_wr_q   <= 1'b0;
            mem_req_q  <= 1'b1;
            tmo_q      <= '0;
            state_q    <= RD_WAIT;
          end
        end
        DRAIN: begin
          if (done | timed_out) begin
            tmo_q <= '0;
            if (timed_out) bus_err_q <= 1'b1;
            // Entries pushed this cycle are picked up from IDLE on the next one.
            if (count_q > CW'(1)) begin
              mem_addr_q  <= wb_addr_q[rd_ptr_inc];
              mem_wdata_q <= wb_data_q[rd_ptr_inc];
            end else begin
              mem_req_q <= 1'b0;
              state_q   <= IDLE;
            end
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        RD_WAIT: begin
          if (done | timed_out) begin
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            cpu_ack_q   <= 1'b1;
            cpu_rdata_q <= done ? mem_rdata_i : 32'hDEAD_BEEF;
            if (timed_out) bus_err_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_rdata_o = cpu_rdata_q;
  assign cpu_ack_o   = cpu_ack_q;
  assign mem_req_o   = mem_req_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign bus_err_o   = bus_err_q;
endmodule

// File: tb/tb_mem_bridge.sv
// Bench for mem_bridge: scoreboard of CPU acks and memory writes against a flat-memory reference model.
// A behavioural RAM answers mem_req with a mode-selected ready pattern.
module tb_mem_bridge;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_wr, cpu_ack, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        mem_req, mem_wr, mem_ready, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_bridge #(.WB_DEPTH(4), .RD_TIMEOUT(8)) dut (
    .clock_i(clk), .reset_i(rst_n),
    .cpu_req_i(cpu_req), .cpu_wr_i(cpu_wr), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack), .cpu_stall_o(cpu_stall),
    .mem_req_o(mem_req), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready), .bus_err_o(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct { bit rd; logic [31:0] data; int exp_cyc; } ack_t;
  typedef struct { logic [31:0] a; logic [31:0] d; } mw_t;

  ack_t        ack_q[$];
  mw_t         mw_q[$];
  int          hs_cyc[$];
  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] fake_mem [logic [31:0]];
  int          vectors = 0, miscompares = 0;
  int          cyc = 0;
  int          mem_mode = 2;   // 0 random (<=3 waits), 1 never ready, 2 always ready, 3 exactly 3 waits
  int          wait_run = 0;
  bit          prev_wait = 0;
  logic [31:0] prev_addr, prev_wdata;
  logic        prev_wr;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic void check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: decides mem_ready each negedge; the handshake it predicts happens at the next posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ready = 1'b0;
      wait_run  = 0;
      prev_wait = 0;
    end else begin
      bit rdy;
      if (prev_wait && mem_req) begin
        check_eq("mem_addr_stable", mem_addr, prev_addr);
        check_eq("mem_wdata_stable", mem_wdata, prev_wdata);
        check_eq("mem_wr_stable", {31'd0, mem_wr}, {31'd0, prev_wr});
      end
      if (!mem_req) wait_run = 0;
      case (mem_mode)
        0:       rdy = (wait_run >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        1:       rdy = 1'b0;
        3:       rdy = (wait_run >= 3);
        default: rdy = 1'b1;
      endcase
      mem_ready = rdy;
      mem_rdata = fake_mem.exists(mem_addr) ? fake_mem[mem_addr] : dflt(mem_addr);
      if (mem_req && rdy) begin
        wait_run = 0;
        hs_cyc.push_back(cyc);
        if (mem_wr) begin
          fake_mem[mem_addr] = mem_wdata;
          if (mw_q.size() == 0) begin
            check_eq("unexpected_mem_write", mem_addr, 32'hFFFF_FFFF);
          end else begin
            mw_t m;
            m = mw_q.pop_front();
            check_eq("mem_write_addr", mem_addr, m.a);
            check_eq("mem_write_data", mem_wdata, m.d);
          end
        end
      end else if (mem_req) begin
        wait_run++;
      end
      prev_wait  = mem_req && !rdy;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
      prev_wr    = mem_wr;
    end
  end

  // Ack monitor: every ack must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && cpu_ack) begin
      if (ack_q.size() == 0) begin
        check_eq("spurious_ack", {31'd0, cpu_ack}, 32'd0);
      end else begin
        ack_t e;
        e = ack_q.pop_front();
        if (e.rd) check_eq("read_data", cpu_rdata, e.data);
        if (e.exp_cyc >= 0) check_eq("ack_latency", cyc, e.exp_cyc);
        $display("ack %s data=%h cycle=%0d", e.rd ? "rd" : "wr", cpu_rdata, cyc);
      end
    end
  end

  task automatic drive(input bit wr, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
  endtask

  // Called at negedge+1 with the request driven; waits for acceptance and records expectations.
  task automatic complete(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit abort_exp);
    int n;
    ack_t e;
    mw_t  m;
    n = 0;
    while (cpu_stall && n < 200) begin
      @(negedge clk); #1; n++;
    end
    check_eq("accept", {31'd0, cpu_stall}, 32'd0);
    if (!cpu_stall) begin
      if (wr) begin
        ref_mem[a] = d;
        m.a = a; m.d = d;
        mw_q.push_back(m);
        e.rd = 0; e.data = '0; e.exp_cyc = cyc + 1;
      end else begin
        e.rd = 1;
        e.data = abort_exp ? 32'hDEAD_BEEF : (ref_mem.exists(a) ? ref_mem[a] : dflt(a));
        e.exp_cyc = (mem_mode == 2) ? cyc + 2 : -1;
      end
      ack_q.push_back(e);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit abort_exp);
    drive(wr, a, d);
    #1;
    complete(wr, a, d, abort_exp);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((ack_q.size() != 0 || mw_q.size() != 0 || mem_req) && n < 500) begin
      @(negedge clk); n++;
    end
    repeat (2) @(negedge clk);
    check_eq("drain_ack_q", ack_q.size(), 0);
    check_eq("drain_mw_q", mw_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    check_eq("rst_cpu_rdata", cpu_rdata, 32'd0);
    check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_bus_err", {31'd0, bus_err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    begin
      bit seen;
      seen = 0;
      repeat (20) begin @(negedge clk); if (mem_req || cpu_ack) seen = 1; end
      check_eq("idle_20_cycles", {31'd0, seen}, 32'd0);
    end

    // Two posted writes, zero-wait RAM: drained in order, back-to-back.
    mem_mode = 2;
    hs_cyc.delete();
    issue(1, 32'h10, 32'h1111, 0);
    issue(1, 32'h14, 32'h2222, 0);
    wait_drain();
    check_eq("b2b_count", hs_cyc.size(), 2);
    if (hs_cyc.size() == 2) check_eq("b2b_spacing", hs_cyc[1] - hs_cyc[0], 1);
    issue(0, 32'h10, 32'h0, 0);   // zero-wait read latency
    wait_drain();

    // Full buffer blocks the fifth write until the first drain completes.
    mem_mode = 1;
    for (int i = 0; i < 4; i++) issue(1, 32'h30 + 32'(4 * i), 32'hA000 + 32'(i), 0);
    drive(1, 32'h40, 32'hA004);
    #1;
    check_eq("full_stall_0", {31'd0, cpu_stall}, 32'd1);
    @(negedge clk); #1;
    check_eq("full_stall_1", {31'd0, cpu_stall}, 32'd1);
    mem_mode = 0;
    complete(1, 32'h40, 32'hA004, 0);
    wait_drain();

    // Read behind a write with a 3-wait RAM.
    mem_mode = 3;
    issue(1, 32'h20, 32'hCAFE, 0);
    issue(0, 32'h20, 32'h0, 0);
    wait_drain();

    // Read timeout.
    mem_mode = 1;
    issue(0, 32'h40, 32'h0, 1);
    wait_drain();
    check_eq("bus_err_set", {31'd0, bus_err}, 32'd1);

    // Randomized traffic in blocks with a fixed RAM mode per block.
    for (int blk = 0; blk < 15; blk++) begin
      mem_mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
      for (int k = 0; k < 20; k++) begin
        logic [31:0] a;
        a = 32'h100 + 32'(4 * $urandom_range(0, 7));
        if ($urandom_range(0, 2) != 0) issue(1, a, $urandom, 0);
        else                           issue(0, a, 32'h0, 0);
      end
      wait_drain();
    end
    check_eq("bus_err_sticky", {31'd0, bus_err}, 32'd1);

    // Reset during a drain drops the buffered writes.
    mem_mode = 1;
    issue(1, 32'h200, 32'h1, 0);
    issue(1, 32'h204, 32'h2, 0);
    issue(1, 32'h208, 32'h3, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_mid_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    check_eq("rst_mid_bus_err", {31'd0, bus_err}, 32'd0);
    ack_q.delete();
    mw_q.delete();
    ref_mem = fake_mem;
    mem_mode = 2;
    @(negedge clk); rst_n = 1'b1;
    begin
      bit seen;
      seen = 0;
      repeat (5) begin @(negedge clk); if (mem_req || cpu_ack) seen = 1; end
      check_eq("post_rst_idle", {31'd0, seen}, 32'd0);
    end
    issue(0, 32'h200, 32'h0, 0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
